uart_tx_mmio: RTL and testbench

Memory-mapped UART transmitter that consumes CPU6 bus writes to the console data address. The default console data address is 0x5A00. It sits beside Memory on the CPU6 address/data bus and snoops the same addressBus, writeEnBus and data_c2r signals. Written bytes go into a small FIFO and are serialised as 8N1 frames on a TX pin. A status register supplies a read path that the top-level data_r2c mux can select.

---
 rtl/uart_tx_mmio.sv | 177 +++++++++++++++++
 tb/tb_uart_tx_mmio.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_mmio.sv
// uart_tx_mmio: snoops CPU writes to BASE_ADDR, queues bytes in a FIFO and sends them LSB-first as 8N1 frames on tx (8E1 when UART_TX_PARITY_EN is defined).
// Latency: start bit appears on tx 2 clocks after the write edge; read_sel/data_out follow the address by 1 clock.
// Backpressure: none toward the CPU; a write to a full FIFO is dropped and sets the sticky overflow status bit.
module uart_tx_mmio #(
    parameter logic [15:0] BASE_ADDR    = 16'h5A00,
    parameter int          CLKS_PER_BIT = 16,
    parameter int          FIFO_AW      = 4
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [15:0] addressBus,
    input  logic        writeEnBus,
    input  logic [7:0]  data_c2r,
    output logic [7:0]  data_out,
    output logic        read_sel,
    output logic        tx,
    output logic        tx_idle
);

    localparam logic [15:0]      STAT_ADDR = BASE_ADDR + 16'd1;
    localparam logic [15:0]      BIT_LAST  = 16'(CLKS_PER_BIT - 1);
    localparam logic [FIFO_AW:0] PTR_ONE   = {{FIFO_AW{1'b0}}, 1'b1};

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
    localparam logic PAR_FLAG = 1'b1;
`else
    typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
    localparam logic PAR_FLAG = 1'b0;
`endif

    logic [7:0]       mem [2**FIFO_AW];
    logic [FIFO_AW:0] wr_ptr, rd_ptr;
    logic             empty, full, push, pop, wr_data, wr_stat, overflow;
    logic [7:0]       head, status;

    state_t      state, state_nxt;
    logic [15:0] cnt, cnt_nxt;
    logic [7:0]  sh, sh_nxt;
    logic [2:0]  bit_idx, bit_nxt;
    logic        tx_nxt;

    assign wr_data = writeEnBus && (addressBus == BASE_ADDR);
    assign wr_stat = writeEnBus && (addressBus == STAT_ADDR);
    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[FIFO_AW] != rd_ptr[FIFO_AW]) &&
                     (wr_ptr[FIFO_AW-1:0] == rd_ptr[FIFO_AW-1:0]);
    // Fullness comes from the pre-edge pointers, so a same-edge pop never rescues a push.
    assign push    = wr_data && !full;
    assign head    = mem[rd_ptr[FIFO_AW-1:0]];
    assign tx_idle = empty && (state == IDLE);
    assign status  = {3'b000, PAR_FLAG, overflow, state != IDLE, full, empty};

    always_ff @(posedge clock) begin
        if (push) mem[wr_ptr[FIFO_AW-1:0]] <= data_c2r;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            overflow <= 1'b0;
            read_sel <= 1'b0;
            data_out <= 8'h00;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_ONE;
            if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
            if (wr_stat)
                overflow <= 1'b0;
            else if (wr_data && full)
                overflow <= 1'b1;
            read_sel <= ((addressBus == BASE_ADDR) || (addressBus == STAT_ADDR)) && !writeEnBus;
            data_out <= (addressBus == STAT_ADDR) ? status : 8'h00;
        end
    end

`ifdef UART_TX_PARITY_EN
    logic par;
    // Data bits are shifted out of sh, so even parity is captured at load time.
    always_ff @(posedge clock) begin
        if (reset)    par <= 1'b0;
        else if (pop) par <= ^head;
    end
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            state   <= IDLE;
            cnt     <= 16'd0;
            sh      <= 8'h00;
            bit_idx <= 3'd0;
            tx      <= 1'b1;
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            sh      <= sh_nxt;
            bit_idx <= bit_nxt;
            tx      <= tx_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        sh_nxt    = sh;
        bit_nxt   = bit_idx;
        pop       = 1'b0;
        tx_nxt    = 1'b1;
        case (state)
            IDLE: begin
                if (!empty) begin
                    pop       = 1'b1;
                    sh_nxt    = head;
                    bit_nxt   = 3'd0;
                    cnt_nxt   = BIT_LAST;
                    state_nxt = START;
                end
            end
            START: begin
                tx_nxt = 1'b0;
                if (cnt == 16'd0) begin
                    cnt_nxt   = BIT_LAST;
                    state_nxt = DATA;
                end else begin
                    cnt_nxt = cnt - 16'd1;
                end
            end
            DATA: begin
                tx_nxt = sh[0];
                if (cnt == 16'd0) begin
                    cnt_nxt = BIT_LAST;
                    sh_nxt  = {1'b0, sh[7:1]};
                    if (bit_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                        state_nxt = PARITY;
`else
                        state_nxt = STOP;
`endif
                    end else begin
                        bit_nxt = bit_idx + 3'd1;
                    end
                end else begin
                    cnt_nxt = cnt - 16'd1;
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                tx_nxt = par;
                if (cnt == 16'd0) begin
                    cnt_nxt   = BIT_LAST;
                    state_nxt = STOP;
                end else begin
                    cnt_nxt = cnt - 16'd1;
                end
            end
`endif
            STOP: begin
                if (cnt == 16'd0) begin
                    // Chain straight into the next start bit when more data is queued.
                    if (!empty) begin
                        pop       = 1'b1;
                        sh_nxt    = head;
                        bit_nxt   = 3'd0;
                        cnt_nxt   = BIT_LAST;
                        state_nxt = START;
                    end else begin
                        state_nxt = IDLE;
                    end
                end else begin
                    cnt_nxt = cnt - 16'd1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule

// File: tb/tb_uart_tx_mmio.sv
// Directed bench for uart_tx_mmio: table of single-byte frames plus hand-written back-to-back, overflow and reset-abort sequences.
module tb_uart_tx_mmio;

    localparam int CPB = 4;
    localparam int AW  = 2;
`ifdef UART_TX_PARITY_EN
    localparam int        NB     = 11;
    localparam logic [7:0] PAR_ST = 8'h10;
`else
    localparam int        NB     = 10;
    localparam logic [7:0] PAR_ST = 8'h00;
`endif

    logic        clock, reset, writeEnBus, read_sel, tx, tx_idle;
    logic [15:0] addressBus;
    logic [7:0]  data_c2r, data_out;

    uart_tx_mmio #(.BASE_ADDR(16'h5A00), .CLKS_PER_BIT(CPB), .FIFO_AW(AW)) dut (
        .clock(clock), .reset(reset), .addressBus(addressBus), .writeEnBus(writeEnBus),
        .data_c2r(data_c2r), .data_out(data_out), .read_sel(read_sel), .tx(tx), .tx_idle(tx_idle)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    typedef struct {logic [10:0] raw; int start;} frame_t;
    frame_t frames[$];

    // line = {stop, d7..d0, start}; par = even parity of the byte
    typedef struct {logic [7:0] data; logic [9:0] line; logic par;} vec_t;
    vec_t vecs[6];

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // Line monitor: samples each bit near its centre, starting at the first low sample.
    initial begin
        forever begin
            @(negedge clock);
            if (!reset && tx === 1'b0) begin
                frame_t f;
                f.raw   = '0;
                f.start = cyc;
                repeat (CPB/2) @(negedge clock);
                f.raw[0] = tx;
                for (int k = 1; k < NB; k++) begin
                    repeat (CPB) @(negedge clock);
                    f.raw[k] = tx;
                end
                frames.push_back(f);
            end
        end
    end

    task automatic bus_write(input logic [15:0] a, input logic [7:0] d);
        @(negedge clock);
        addressBus = a; data_c2r = d; writeEnBus = 1'b1;
        @(negedge clock);
        writeEnBus = 1'b0; addressBus = 16'h0000;
    endtask

    task automatic bus_read(input logic [15:0] a, output logic [7:0] d, output logic s);
        @(negedge clock);
        addressBus = a; writeEnBus = 1'b0;
        @(negedge clock);
        d = data_out; s = read_sel;
        addressBus = 16'h0000;
    endtask

    task automatic wait_idle(output int n);
        n = 0;
        while (!tx_idle && n < 1000) begin
            @(negedge clock);
            n++;
        end
    endtask

    task automatic wait_frames(input string name, input int n);
        int k = 0;
        while (frames.size() < n && k < 2000) begin
            @(negedge clock);
            k++;
        end
        check(name, 32'(frames.size()), 32'(n));
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish, required finish before 500us");
        $fatal(1);
    end

    logic [7:0]  rd;
    logic        rs;
    logic [10:0] exp_raw;
    int          wcyc, n, lows, s0, s1;
    frame_t      f, g;

    initial begin
        vecs[0] = '{8'h41, 10'b1010000010, 1'b0};
        vecs[1] = '{8'h00, 10'b1000000000, 1'b0};
        vecs[2] = '{8'hFF, 10'b1111111110, 1'b0};
        vecs[3] = '{8'hA5, 10'b1101001010, 1'b0};
        vecs[4] = '{8'h07, 10'b1000001110, 1'b1};
        vecs[5] = '{8'h80, 10'b1100000000, 1'b1};

        reset = 1'b1; addressBus = 16'h0000; writeEnBus = 1'b0; data_c2r = 8'h00;
        repeat (3) @(negedge clock);
        check("rst_tx", 32'(tx), 32'd1);
        check("rst_tx_idle", 32'(tx_idle), 32'd1);
        check("rst_read_sel", 32'(read_sel), 32'd0);
        check("rst_data_out", 32'(data_out), 32'd0);
        reset = 1'b0;

        // Idle line and one-cycle read latency
        lows = 0;
        repeat (20) begin
            @(negedge clock);
            if (tx !== 1'b1) lows++;
        end
        check("idle_tx_low_cycles", 32'(lows), 32'd0);
        check("idle_tx_idle", 32'(tx_idle), 32'd1);
        @(negedge clock);
        addressBus = 16'h5A01;
        check("rd_sel_before_edge", 32'(read_sel), 32'd0);
        @(negedge clock);
        check("rd_stat_sel", 32'(read_sel), 32'd1);
        check("rd_stat_val", 32'(data_out), 32'(8'h01 | PAR_ST));
        addressBus = 16'h5A00;
        @(negedge clock);
        check("rd_data_sel", 32'(read_sel), 32'd1);
        check("rd_data_val", 32'(data_out), 32'd0);
        addressBus = 16'h1234;
        @(negedge clock);
        check("rd_other_sel", 32'(read_sel), 32'd0);
        addressBus = 16'h0000;

        // Single-byte frames from the table
        for (int i = 0; i < 6; i++) begin
            @(negedge clock);
            addressBus = 16'h5A00; data_c2r = vecs[i].data; writeEnBus = 1'b1;
            @(negedge clock);
            writeEnBus = 1'b0; addressBus = 16'h0000;
            wcyc = cyc;
            wait_idle(n);
            // One edge to pop, then NB bit periods of CPB clocks
            check($sformatf("vec%0d_idle_after", i), 32'(n), 32'(1 + NB*CPB));
            wait_frames($sformatf("vec%0d_frames", i), 1);
            if (frames.size() > 0) begin
                f = frames.pop_front();
`ifdef UART_TX_PARITY_EN
                exp_raw = {1'b1, vecs[i].par, vecs[i].line[8:0]};
`else
                exp_raw = {1'b0, vecs[i].line};
`endif
                check($sformatf("vec%0d_start_lat", i), 32'(f.start - wcyc), 32'd2);
                check($sformatf("vec%0d_line", i), 32'(f.raw), 32'(exp_raw));
            end
            repeat (5) @(negedge clock);
        end

        // Back-to-back "Hi": no idle gap between frames
        @(negedge clock);
        addressBus = 16'h5A00; data_c2r = 8'h48; writeEnBus = 1'b1;
        @(negedge clock);
        data_c2r = 8'h69;
        @(negedge clock);
        writeEnBus = 1'b0; addressBus = 16'h0000;
        wait_frames("hi_frames", 2);
        if (frames.size() >= 2) begin
            f = frames.pop_front();
            g = frames.pop_front();
            check("hi_byte0", 32'(f.raw[8:1]), 32'h48);
            check("hi_byte1", 32'(g.raw[8:1]), 32'h69);
            check("hi_stop0", 32'(f.raw[NB-1]), 32'd1);
            check("hi_gap", 32'(g.start - f.start), 32'(NB*CPB));
            $display("uart monitor: %c%c", f.raw[8:1], g.raw[8:1]);
        end
        wait_idle(n);
        repeat (5) @(negedge clock);

        // Overflow: one byte in flight plus six more, FIFO holds four
        for (int i = 0; i < 7; i++) begin
            @(negedge clock);
            addressBus = 16'h5A00; data_c2r = 8'h30 + 8'(i); writeEnBus = 1'b1;
        end
        @(negedge clock);
        writeEnBus = 1'b0; addressBus = 16'h0000;
        bus_read(16'h5A01, rd, rs);
        check("ovf_status", 32'(rd), 32'(8'h0E | PAR_ST));
        check("ovf_read_sel", 32'(rs), 32'd1);
        bus_write(16'h5A01, 8'h00);
        bus_read(16'h5A01, rd, rs);
        check("ovf_cleared_status", 32'(rd), 32'(8'h06 | PAR_ST));
        wait_frames("ovf_frames", 5);
        wait_idle(n);
        repeat (30) @(negedge clock);
        check("ovf_frame_count", 32'(frames.size()), 32'd5);
        for (int i = 0; i < 5; i++) begin
            if (frames.size() > 0) begin
                f = frames.pop_front();
                check($sformatf("ovf_byte%0d", i), 32'(f.raw[8:1]), 32'(8'h30 + 8'(i)));
            end
        end

        // Reset ten clocks into a frame with a second byte queued
        @(negedge clock);
        addressBus = 16'h5A00; data_c2r = 8'h55; writeEnBus = 1'b1;
        @(negedge clock);
        data_c2r = 8'h66;
        @(negedge clock);
        writeEnBus = 1'b0; addressBus = 16'h0000;
        n = 0;
        while (tx !== 1'b0 && n < 50) begin
            @(negedge clock);
            n++;
        end
        check("rstmid_tx_fell", 32'(tx), 32'd0);
        repeat (9) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        check("rstmid_tx", 32'(tx), 32'd1);
        check("rstmid_tx_idle", 32'(tx_idle), 32'd1);
        reset = 1'b0;
        bus_read(16'h5A01, rd, rs);
        check("rstmid_status", 32'(rd), 32'(8'h01 | PAR_ST));
        lows = 0;
        repeat (60) begin
            @(negedge clock);
            if (tx !== 1'b1) lows++;
        end
        check("rstmid_no_more_bits", 32'(lows), 32'd0);
        check("rstmid_idle_end", 32'(tx_idle), 32'd1);
        frames.delete();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
